// File: rtl/ring_meas_ctrl.sv
// Gated ring oscillator sequencer and frequency meter: enables the ring, waits a settle time, counts synchronized rising edges over a window.
// Optional RING_WDOG_EN adds an o_stall flag for a dead or silent ring.
`timescale 1ns/100ps
module ring_meas_ctrl #(
  parameter int SETTLE_CYC = 8,
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win_cycles,
  input  logic             i_ring_out,
  output logic             o_ring_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_sat
`ifdef RING_WDOG_EN
  ,
  output logic             o_stall
`endif
);

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEAS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic             r_ringEn;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] r_winCtr;
  logic [SET_W-1:0] r_settleCtr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_satInt;
  logic [CNT_W-1:0] r_edgeCount;
  logic             r_sat;

  logic             w_accept;
  logic             w_zeroWin;
  logic             w_settleEnd;
  logic             w_measEnd;
  logic             w_rise;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_satNext;

`ifdef RING_WDOG_EN
  logic             r_stall;
  logic             r_settleAct;
`endif

  assign w_rise    = r_sync2 & ~r_sync3;
  assign w_cntNext = (w_rise && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_satNext = r_satInt | (w_rise && (r_cnt == CNT_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_zeroWin   = 1'b0;
    w_settleEnd = 1'b0;
    w_measEnd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          if (i_win_cycles == '0) begin
            w_zeroWin   = 1'b1;
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (r_settleCtr == SETTLE_LAST) begin
          w_settleEnd = 1'b1;
          w_nextState = S_MEAS;
        end
      end
      S_MEAS: begin
        if (r_winCtr == (r_win - WIN_W'(1))) begin
          w_measEnd   = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Synchronizer is flushed while the ring is gated off so no stale level leaks into the next window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else if (!r_ringEn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_ring_out;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ringEn    <= 1'b0;
      r_win       <= '0;
      r_winCtr    <= '0;
      r_settleCtr <= '0;
      r_cnt       <= '0;
      r_satInt    <= 1'b0;
      r_edgeCount <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win       <= i_win_cycles;
        r_settleCtr <= '0;
        if (w_zeroWin) begin
          r_edgeCount <= '0;
          r_sat       <= 1'b0;
        end else begin
          r_ringEn <= 1'b1;
        end
      end
      if (r_state == S_SETTLE) begin
        r_settleCtr <= r_settleCtr + SET_W'(1);
        if (w_settleEnd) begin
          r_winCtr <= '0;
          r_cnt    <= '0;
          r_satInt <= 1'b0;
        end
      end
      // The final window cycle's rise is folded straight into the reported count.
      if (r_state == S_MEAS) begin
        r_cnt    <= w_cntNext;
        r_satInt <= w_satNext;
        r_winCtr <= r_winCtr + WIN_W'(1);
        if (w_measEnd) begin
          r_ringEn    <= 1'b0;
          r_edgeCount <= w_cntNext;
          r_sat       <= w_satNext;
        end
      end
    end
  end

`ifdef RING_WDOG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall     <= 1'b0;
      r_settleAct <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stall     <= 1'b0;
        r_settleAct <= 1'b0;
      end
      if ((r_state == S_SETTLE) && (r_sync2 ^ r_sync3)) begin
        r_settleAct <= 1'b1;
      end
      if (w_measEnd) begin
        r_stall <= (w_cntNext == '0) || !r_settleAct;
      end
    end
  end

  assign o_stall = r_stall;
`endif

  assign o_ring_en    = r_ringEn;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_edge_count = r_edgeCount;
  assign o_sat        = r_sat;

endmodule

// File: tb/tb_ring_meas_ctrl.sv
// Directed bench for ring_meas_ctrl with behavioural 18ns ring models; stall checks build only with RING_WDOG_EN.
`timescale 1ns/100ps
module tb_ring_meas_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start0, start4;
  logic [15:0] win0, win4;
  logic        ring0, ring4;
  logic        tie0;
  logic        en0, busy0, done0, sat0;
  logic [15:0] cnt0;
  logic        en4, busy4, done4, sat4;
  logic [3:0]  cnt4;
`ifdef RING_WDOG_EN
  logic        stall0, stall4;
`endif

  int vectors;
  int miscompares;

  ring_meas_ctrl #(.SETTLE_CYC(8), .WIN_W(16), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_win_cycles(win0), .i_ring_out(ring0),
    .o_ring_en(en0), .o_busy(busy0), .o_done(done0), .o_edge_count(cnt0), .o_sat(sat0)
`ifdef RING_WDOG_EN
    , .o_stall(stall0)
`endif
  );

  ring_meas_ctrl #(.SETTLE_CYC(8), .WIN_W(16), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_win_cycles(win4), .i_ring_out(ring4),
    .o_ring_en(en4), .o_busy(busy4), .o_done(done4), .o_edge_count(cnt4), .o_sat(sat4)
`ifdef RING_WDOG_EN
    , .o_stall(stall4)
`endif
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Gated ring: held low while disabled, toggles every 9ns once enabled; the 0.5ns offset keeps edges off clk edges.
  always begin
    if (en0 && !tie0) begin
      #9;
      if (en0 && !tie0) ring0 = ~ring0;
      else ring0 = 1'b0;
    end else begin
      ring0 = 1'b0;
      @(en0 or tie0);
      #0.5;
    end
  end

  always begin
    if (en4) begin
      #9;
      if (en4) ring4 = ~ring4;
      else ring4 = 1'b0;
    end else begin
      ring4 = 1'b0;
      @(en4);
      #0.5;
    end
  end

  task automatic doMeas0(input logic [15:0] w, output int cyc, output int enCyc, output int busyCyc);
    cyc = 0; enCyc = 0; busyCyc = 0;
    start0 = 1'b1;
    win0   = w;
    do begin
      @(negedge clk);
      cyc++;
      enCyc   += int'(en0);
      busyCyc += int'(busy0);
      if (cyc == 1) begin
        start0 = 1'b0;
        win0   = 16'd5;
      end
    end while (!done0 && cyc < 2000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start4 = 1'b0; win0 = '0; win4 = '0; tie0 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (en0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ring_en: got %b want 0", en0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done0); end
    vectors++; if (cnt0 !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", cnt0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sat: got %b want 0", sat0); end
`ifdef RING_WDOG_EN
    vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", stall0); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_measure();
    int cyc, enCyc, busyCyc;
    doMeas0(16'd100, cyc, enCyc, busyCyc);
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("[TB] FAIL meas_timeout: done=%b want 1", done0); end
    vectors++; if (cyc !== 109) begin miscompares++; $display("[TB] FAIL meas_latency: got %0d want 109", cyc); end
    vectors++; if (enCyc !== 108) begin miscompares++; $display("[TB] FAIL meas_en_cycles: got %0d want 108", enCyc); end
    vectors++; if (busyCyc !== 109) begin miscompares++; $display("[TB] FAIL meas_busy_cycles: got %0d want 109", busyCyc); end
    vectors++; if (!(cnt0 >= 16'd22 && cnt0 <= 16'd23)) begin miscompares++; $display("[TB] FAIL meas_count: got %0d want 22..23", cnt0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("[TB] FAIL meas_sat: got %b want 0", sat0); end
    @(negedge clk);
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL meas_done_pulse: got %b want 0", done0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL meas_idle_after: got %b want 0", busy0); end
  endtask

  task automatic test_reset_abort();
    int cyc, enCyc, busyCyc;
    start0 = 1'b1;
    win0   = 16'd100;
    for (int c = 1; c <= 59; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
    end
    vectors++; if (en0 !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_pre_en: got %b want 1", en0); end
    rst_n = 1'b0;
    #0.1;
    vectors++; if (en0 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ring_en: got %b want 0", en0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done: got %b want 0", done0); end
    vectors++; if (cnt0 !== 16'd0) begin miscompares++; $display("[TB] FAIL abort_count: got %0d want 0", cnt0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    doMeas0(16'd10, cyc, enCyc, busyCyc);
    vectors++; if (cyc !== 19) begin miscompares++; $display("[TB] FAIL abort_rerun_latency: got %0d want 19", cyc); end
    vectors++; if (!(cnt0 >= 16'd2 && cnt0 <= 16'd3)) begin miscompares++; $display("[TB] FAIL abort_rerun_count: got %0d want 2..3", cnt0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_rerun_sat: got %b want 0", sat0); end
    @(negedge clk);
  endtask

  task automatic test_zero_win();
    int cyc, enCyc, busyCyc;
    doMeas0(16'd0, cyc, enCyc, busyCyc);
    vectors++; if (cyc !== 1) begin miscompares++; $display("[TB] FAIL zero_latency: got %0d want 1", cyc); end
    vectors++; if (enCyc !== 0) begin miscompares++; $display("[TB] FAIL zero_ring_en: got %0d want 0", enCyc); end
    vectors++; if (busyCyc !== 1) begin miscompares++; $display("[TB] FAIL zero_busy_cycles: got %0d want 1", busyCyc); end
    vectors++; if (cnt0 !== 16'd0) begin miscompares++; $display("[TB] FAIL zero_count: got %0d want 0", cnt0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_sat: got %b want 0", sat0); end
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_idle_after: got %b want 0", busy0); end
  endtask

  task automatic test_saturate();
    int cyc;
    cyc = 0;
    start4 = 1'b1;
    win4   = 16'd200;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start4 = 1'b0;
    end while (!done4 && cyc < 2000);
    vectors++; if (cyc !== 209) begin miscompares++; $display("[TB] FAIL sat_latency: got %0d want 209", cyc); end
    vectors++; if (cnt4 !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_count: got %0d want 15", cnt4); end
    vectors++; if (sat4 !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_flag: got %b want 1", sat4); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k, nDone;
    int doneAt[3];
    k = 0; nDone = 0;
    doneAt[0] = 0; doneAt[1] = 0; doneAt[2] = 0;
    start0 = 1'b1;
    win0   = 16'd20;
    while (nDone < 3 && k < 500) begin
      @(negedge clk);
      k++;
      if (done0) begin
        doneAt[nDone] = k;
        nDone++;
        vectors++;
        if (!(cnt0 >= 16'd4 && cnt0 <= 16'd5)) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d want 4..5", cnt0); end
      end
    end
    start0 = 1'b0;
    vectors++; if (nDone !== 3) begin miscompares++; $display("[TB] FAIL b2b_pulses: got %0d want 3", nDone); end
    vectors++; if (doneAt[0] !== 29) begin miscompares++; $display("[TB] FAIL b2b_first: got %0d want 29", doneAt[0]); end
    vectors++; if (doneAt[1] - doneAt[0] !== 30) begin miscompares++; $display("[TB] FAIL b2b_gap1: got %0d want 30", doneAt[1] - doneAt[0]); end
    vectors++; if (doneAt[2] - doneAt[1] !== 30) begin miscompares++; $display("[TB] FAIL b2b_gap2: got %0d want 30", doneAt[2] - doneAt[1]); end
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_after: got %b want 0", busy0); end
  endtask

  task automatic test_dead_ring();
    int cyc, enCyc, busyCyc;
    tie0 = 1'b1;
    @(negedge clk);
    doMeas0(16'd50, cyc, enCyc, busyCyc);
    vectors++; if (cyc !== 59) begin miscompares++; $display("[TB] FAIL dead_latency: got %0d want 59", cyc); end
    vectors++; if (cnt0 !== 16'd0) begin miscompares++; $display("[TB] FAIL dead_count: got %0d want 0", cnt0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("[TB] FAIL dead_sat: got %b want 0", sat0); end
`ifdef RING_WDOG_EN
    vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("[TB] FAIL dead_stall: got %b want 1", stall0); end
`endif
    tie0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    win0   = 16'd20;
    @(negedge clk);
    start0 = 1'b0;
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL dead_restart_busy: got %b want 1", busy0); end
`ifdef RING_WDOG_EN
    vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("[TB] FAIL dead_stall_clear: got %b want 0", stall0); end
`endif
    cyc = 1;
    while (!done0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    vectors++; if (!(cnt0 >= 16'd4 && cnt0 <= 16'd5)) begin miscompares++; $display("[TB] FAIL dead_recover_count: got %0d want 4..5", cnt0); end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_measure();
    test_reset_abort();
    test_zero_win();
    test_saturate();
    test_back_to_back();
    test_dead_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation still running at 400us, want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
